// File: rtl/regfile_wb_scheduler.sv
// rtl/regfile_wb_scheduler.sv - register file write-port scheduler with RR writeback arbitration
// Busy scoreboard gates issue; one registered write per cycle retires a pending destination.
module regfile_wb_scheduler #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32,
   parameter int MAX_OUT    = 4,
   localparam int NREG      = 2**ADDR_WIDTH,
   localparam int CW        = $clog2(MAX_OUT+1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  issue_valid,
   input  logic                  issue_wr,
   input  logic [ADDR_WIDTH-1:0] issue_rd,
   input  logic [ADDR_WIDTH-1:0] issue_rs1,
   input  logic [ADDR_WIDTH-1:0] issue_rs2,
   output logic                  issue_ready,
   input  logic                  wb0_valid,
   input  logic [ADDR_WIDTH-1:0] wb0_rd,
   input  logic [DATA_WIDTH-1:0] wb0_data,
   output logic                  wb0_ready,
   input  logic                  wb1_valid,
   input  logic [ADDR_WIDTH-1:0] wb1_rd,
   input  logic [DATA_WIDTH-1:0] wb1_data,
   output logic                  wb1_ready,
   output logic                  rf_wen,
   output logic [ADDR_WIDTH-1:0] rf_waddr,
   output logic [DATA_WIDTH-1:0] rf_wdata,
   output logic [NREG-1:0]       busy_mask,
   output logic [CW-1:0]         outstanding,
   output logic                  wb_err
);

   logic [NREG-1:0]       busy_q, busy_nxt;
   logic [CW-1:0]         out_q, out_nxt;
   logic                  rr_q;
   logic                  hz, set_en, gnt0, gnt1, contested;
   logic                  ret_hit, ret_ok, spurious;
   logic [ADDR_WIDTH-1:0] g_rd;
   logic [DATA_WIDTH-1:0] g_data;

   assign busy_mask   = busy_q;
   assign outstanding = out_q;

   // busy_q[0] is never set, so x0 sources/destinations cannot hazard
   always_comb begin
      hz          = busy_q[issue_rs1] | busy_q[issue_rs2] | (issue_wr & busy_q[issue_rd]);
      issue_ready = !hz && !(issue_wr && (issue_rd != '0) && (out_q == CW'(MAX_OUT)));
      set_en      = issue_valid & issue_ready & issue_wr & (issue_rd != '0);
   end

   always_comb begin
      contested = wb0_valid & wb1_valid;
      gnt0      = wb0_valid & (!wb1_valid | !rr_q);
      gnt1      = wb1_valid & (!wb0_valid |  rr_q);
      wb0_ready = gnt0;
      wb1_ready = gnt1;
      g_rd      = gnt1 ? wb1_rd   : wb0_rd;
      g_data    = gnt1 ? wb1_data : wb0_data;
   end

   // A write landing on a non-busy index was never issued: flag it, do not retire it
   always_comb begin
      ret_hit  = rf_wen & (rf_waddr != '0);
      ret_ok   = ret_hit &  busy_q[rf_waddr];
      spurious = ret_hit & !busy_q[rf_waddr];
      busy_nxt = busy_q;
      if (ret_ok) busy_nxt[rf_waddr] = 1'b0;
      if (set_en) busy_nxt[issue_rd] = 1'b1;
      busy_nxt[0] = 1'b0;
      out_nxt = out_q;
      if (set_en && !ret_ok)
         out_nxt = out_q + CW'(1);
      else if (!set_en && ret_ok && (out_q != '0))
         out_nxt = out_q - CW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q   <= '0;
         out_q    <= '0;
         rr_q     <= 1'b0;
         rf_wen   <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
         wb_err   <= 1'b0;
      end else begin
         busy_q <= busy_nxt;
         out_q  <= out_nxt;
         if (contested) rr_q <= !rr_q;
         if ((gnt0 || gnt1) && (g_rd != '0)) begin
            rf_wen   <= 1'b1;
            rf_waddr <= g_rd;
            rf_wdata <= g_data;
         end else begin
            rf_wen   <= 1'b0;
         end
         if (spurious) wb_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// tb/tb_regfile_wb_scheduler.sv - directed bench for regfile_wb_scheduler
// Scoreboard model of busy set / pending count / RR preference checked every negedge.
module tb_regfile_wb_scheduler;
   localparam int AW = 5;
   localparam int DW = 32;
   localparam int MO = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          issue_valid = 0, issue_wr = 0;
   logic [AW-1:0] issue_rd = 0, issue_rs1 = 0, issue_rs2 = 0;
   logic          issue_ready;
   logic          wb0_valid = 0, wb1_valid = 0;
   logic [AW-1:0] wb0_rd = 0, wb1_rd = 0;
   logic [DW-1:0] wb0_data = 0, wb1_data = 0;
   logic          wb0_ready, wb1_ready;
   logic          rf_wen;
   logic [AW-1:0] rf_waddr;
   logic [DW-1:0] rf_wdata;
   logic [31:0]   busy_mask;
   logic [2:0]    outstanding;
   logic          wb_err;

   int n_total = 0;
   int n_pass  = 0;

   regfile_wb_scheduler dut (
      .clk(clk), .rst_n(rst_n),
      .issue_valid(issue_valid), .issue_wr(issue_wr), .issue_rd(issue_rd),
      .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_ready(issue_ready),
      .wb0_valid(wb0_valid), .wb0_rd(wb0_rd), .wb0_data(wb0_data), .wb0_ready(wb0_ready),
      .wb1_valid(wb1_valid), .wb1_rd(wb1_rd), .wb1_data(wb1_data), .wb1_ready(wb1_ready),
      .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .busy_mask(busy_mask), .outstanding(outstanding), .wb_err(wb_err)
   );

   always #5 clk = ~clk;

   // Model state: set of pending destinations, their count, whose turn on contention
   bit          m_busy[32];
   int          m_out  = 0;
   int          m_turn = 0;
   bit          m_wen  = 0;
   int          m_addr = 0;
   logic [31:0] m_data = 0;
   bit          m_err  = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   function automatic bit m_ready();
      bit hazard;
      hazard = m_busy[issue_rs1] || m_busy[issue_rs2] || (issue_wr && m_busy[issue_rd]);
      return !hazard && !(issue_wr && issue_rd != 0 && m_out == MO);
   endfunction

   function automatic bit m_g0();
      return wb0_valid && (!wb1_valid || m_turn == 0);
   endfunction

   function automatic bit m_g1();
      return wb1_valid && (!wb0_valid || m_turn == 1);
   endfunction

   function automatic logic [31:0] m_mask();
      logic [31:0] m;
      for (int i = 0; i < 32; i++) m[i] = m_busy[i];
      return m;
   endfunction

   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            for (int i = 0; i < 32; i++) m_busy[i] = 0;
            m_out = 0; m_turn = 0; m_wen = 0; m_addr = 0; m_data = 0; m_err = 0;
         end else begin
            bit rdy, g0, g1;
            int grd;
            logic [31:0] gd;
            rdy = m_ready(); g0 = m_g0(); g1 = m_g1();
            if (m_wen && m_addr != 0) begin
               if (m_busy[m_addr]) begin m_busy[m_addr] = 0; m_out--; end
               else m_err = 1;
            end
            if (issue_valid && rdy && issue_wr && issue_rd != 0) begin
               m_busy[issue_rd] = 1; m_out++;
            end
            if (wb0_valid && wb1_valid) m_turn = 1 - m_turn;
            grd = g1 ? int'(wb1_rd) : int'(wb0_rd);
            gd  = g1 ? wb1_data : wb0_data;
            if ((g0 || g1) && grd != 0) begin
               m_wen = 1; m_addr = grd; m_data = gd;
            end else m_wen = 0;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         chk("issue_ready", issue_ready, m_ready());
         chk("wb0_ready", wb0_ready, m_g0());
         chk("wb1_ready", wb1_ready, m_g1());
         chk("rf_wen", rf_wen, m_wen);
         chk("rf_waddr", rf_waddr, m_addr);
         chk("rf_wdata", rf_wdata, m_data);
         chk("busy_mask", busy_mask, m_mask());
         chk("outstanding", outstanding, m_out);
         chk("wb_err", wb_err, m_err);
      end
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic issue(input logic wr, input int rd, input int rs1, input int rs2);
      issue_valid = 1; issue_wr = wr;
      issue_rd = AW'(rd); issue_rs1 = AW'(rs1); issue_rs2 = AW'(rs2);
   endtask

   initial begin
      step(); step();
      chk("rst_busy", busy_mask, 0);
      chk("rst_out", outstanding, 0);
      chk("rst_wen", rf_wen, 0);
      chk("rst_err", wb_err, 0);
      rst_n = 1;

      issue(1, 5, 0, 0); #1;
      chk("t1_ready", issue_ready, 1);
      step();
      issue(0, 0, 5, 0); #1;
      chk("t1_busy5", busy_mask[5], 1);
      chk("t1_out", outstanding, 1);
      chk("t1_raw", issue_ready, 0);
      step(); issue_valid = 0;

      wb0_valid = 1; wb0_rd = 5; wb0_data = 32'hDEADBEEF; #1;
      chk("t2_gnt0", wb0_ready, 1);
      step(); wb0_valid = 0; #1;
      chk("t2_wen", rf_wen, 1);
      chk("t2_waddr", rf_waddr, 5);
      chk("t2_wdata", rf_wdata, 32'hDEADBEEF);
      step();
      issue(0, 0, 5, 0); #1;
      chk("t2_busy5", busy_mask[5], 0);
      chk("t2_ready", issue_ready, 1);
      step(); issue_valid = 0;

      rst_n = 0; #1; rst_n = 1;
      issue(1, 3, 0, 0); step();
      issue(1, 4, 0, 0); step(); issue_valid = 0;
      wb0_valid = 1; wb0_rd = 3; wb0_data = 32'h33;
      wb1_valid = 1; wb1_rd = 4; wb1_data = 32'h44; #1;
      chk("t3_g0", {wb0_ready, wb1_ready}, 2'b10);
      step(); #1;
      chk("t3_g1", {wb0_ready, wb1_ready}, 2'b01);
      chk("t3_w3", {rf_wen, rf_waddr}, {1'b1, 5'd3});
      step(); wb0_valid = 0; wb1_valid = 0; #1;
      chk("t3_w4", {rf_wen, rf_waddr}, {1'b1, 5'd4});
      chk("t3_d4", rf_wdata, 32'h44);
      step(); step();
      chk("t3_out", outstanding, 0);

      for (int r = 10; r < 14; r++) begin issue(1, r, 0, 0); step(); end
      issue(1, 14, 0, 0); #1;
      chk("t4_full", issue_ready, 0);
      issue(0, 14, 1, 2); #1;
      chk("t4_nowr", issue_ready, 1);
      step(); issue_valid = 0;
      wb0_valid = 1; wb0_rd = 10; wb0_data = 32'h1010;
      step(); wb0_valid = 0;
      issue(1, 14, 0, 0); #1;
      chk("t4_nobypass", issue_ready, 0);
      step();
      chk("t4_out3", outstanding, 3);
      chk("t4_retry", issue_ready, 1);
      step(); issue_valid = 0;
      chk("t4_out4", outstanding, 4);

      wb1_valid = 1; wb1_rd = 7; wb1_data = 32'h77;
      step(); wb1_valid = 0;
      chk("t5_wen", rf_wen, 1);
      chk("t5_err0", wb_err, 0);
      step();
      chk("t5_err1", wb_err, 1);
      chk("t5_out", outstanding, 4);
      step();
      chk("t5_sticky", wb_err, 1);
      wb0_valid = 1; wb0_rd = 0; wb0_data = 32'h123; #1;
      chk("t5_x0gnt", wb0_ready, 1);
      step(); wb0_valid = 0;
      chk("t5_x0wen", rf_wen, 0);

      wb0_valid = 1; wb0_rd = 11; wb0_data = 32'hB;
      step(); wb0_valid = 0;
      chk("t6_wen", rf_wen, 1);
      rst_n = 0; #1;
      chk("t6_rst", {rf_wen, rf_waddr, rf_wdata, busy_mask, outstanding, wb_err}, 0);
      step(); step();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
